// File: rtl/exec_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_muldiv_if
// Brief    : Issue, speculation-flush and result-bus bundle for exec_muldiv
// Revision : 1.0 - initial release
// ============================================================================
interface exec_muldiv_if #(
    parameter int BUF_SIZE_LOG = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [9:0]            in_op;
    logic [31:0]           in_vj;
    logic [31:0]           in_vk;
    logic [BUF_SIZE_LOG:0] in_tag;
    logic [5:0]            in_spec_tag;
    logic                  flush_valid;
    logic [5:0]            flush_mask;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_value;
    logic [BUF_SIZE_LOG:0] out_tag;
    logic [5:0]            out_spec_tag;

    // Issue stage, branch unit and result-bus arbiter side
    modport master (
        output in_valid, in_op, in_vj, in_vk, in_tag, in_spec_tag,
        output flush_valid, flush_mask, out_ready,
        input  in_ready, out_valid, out_value, out_tag, out_spec_tag
    );

    // Execution unit side
    modport slave (
        input  in_valid, in_op, in_vj, in_vk, in_tag, in_spec_tag,
        input  flush_valid, flush_mask, out_ready,
        output in_ready, out_valid, out_value, out_tag, out_spec_tag
    );
endinterface
`default_nettype wire

// File: rtl/exec_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : exec_muldiv
// Brief    : RV32M execution unit - two-cycle multiply, 32-step restoring
//            divide, result held until the result bus grants it, killed by a
//            matching speculation flush
// Revision : 1.0 - initial release
// ============================================================================
module exec_muldiv #(
    parameter int BUF_SIZE_LOG = 4
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    exec_muldiv_if.slave bus
);
    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_MUL       = 3'd1;
    localparam logic [2:0] c_DIV       = 3'd2;
    localparam logic [2:0] c_FIX       = 3'd3;
    localparam logic [2:0] c_DONE      = 3'd4;
    localparam logic [5:0] c_LAST_ITER = 6'd31;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [2:0]            r_op;
    logic [31:0]           r_vj;
    logic [31:0]           r_vk;
    logic [BUF_SIZE_LOG:0] r_tag;
    logic [5:0]            r_spec;
    logic [31:0]           r_result;
    logic [5:0]            r_cnt;
    logic [31:0]           r_quo;
    logic [31:0]           r_rem;
    logic [31:0]           r_dvs;
    logic                  r_neg_q;
    logic                  r_neg_r;

    // Only funct3 selects behaviour; the upper op bits are don't-care here
    logic [2:0]  w_f3;
    logic        w_unused_op;
    assign w_f3        = bus.in_op[2:0];
    assign w_unused_op = ^bus.in_op[9:3];

    // Accept / kill qualification
    logic w_kill_in;
    logic w_accept;
    logic w_kill;
    assign w_kill_in = bus.flush_valid && (|(bus.flush_mask & bus.in_spec_tag));
    assign w_accept  = bus.in_valid && (r_state == c_IDLE) && !w_kill_in;
    assign w_kill    = bus.flush_valid && (|(bus.flush_mask & r_spec)) && (r_state != c_IDLE);

    // Divide setup: special cases resolve at accept, others load magnitudes
    logic        w_is_div;
    logic        w_div_signed;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_special;
    logic [31:0] w_special_val;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    assign w_is_div      = w_f3[2];
    assign w_div_signed  = ~w_f3[0];
    assign w_div_zero    = (bus.in_vk == 32'd0);
    assign w_div_ovf     = w_div_signed && (bus.in_vj == 32'h8000_0000) && (bus.in_vk == 32'hFFFF_FFFF);
    assign w_special     = w_is_div && (w_div_zero || w_div_ovf);
    assign w_special_val = w_div_zero ? (w_f3[1] ? bus.in_vj : 32'hFFFF_FFFF)
                                      : (w_f3[1] ? 32'd0     : 32'h8000_0000);
    assign w_neg_a       = w_div_signed & bus.in_vj[31];
    assign w_neg_b       = w_div_signed & bus.in_vk[31];
    assign w_abs_a       = w_neg_a ? (32'd0 - bus.in_vj) : bus.in_vj;
    assign w_abs_b       = w_neg_b ? (32'd0 - bus.in_vk) : bus.in_vk;

    // Multiplier: operands sign/zero-extended to 64 bits, low 64 of the
    // product hold both the MUL word and the high word of the 33x33 product
    logic        w_mul_a_sgn;
    logic        w_mul_b_sgn;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic [31:0] w_mul_res;
    assign w_mul_a_sgn = (r_op != 3'd3);
    assign w_mul_b_sgn = (r_op == 3'd0) || (r_op == 3'd1);
    assign w_mul_a     = {{32{w_mul_a_sgn & r_vj[31]}}, r_vj};
    assign w_mul_b     = {{32{w_mul_b_sgn & r_vk[31]}}, r_vk};
    assign w_prod      = w_mul_a * w_mul_b;
    assign w_mul_res   = (r_op == 3'd0) ? w_prod[31:0] : w_prod[63:32];

    // Restoring divider step: partial remainder always stays below divisor,
    // so the 32-bit subtraction cannot lose information
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [31:0] w_div_res;
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_rem_nxt = w_ge ? (w_shift[31:0] - r_dvs) : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_ge};
    assign w_q_fix   = r_neg_q ? (32'd0 - r_quo) : r_quo;
    assign w_r_fix   = r_neg_r ? (32'd0 - r_rem) : r_rem;
    assign w_div_res = r_op[1] ? w_r_fix : w_q_fix;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state selection; a matching flush overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (!w_is_div)     w_state_nxt = c_MUL;
                    else if (w_special) w_state_nxt = c_DONE;
                    else               w_state_nxt = c_DIV;
                end
            end
            c_MUL:   w_state_nxt = c_DONE;
            c_DIV:   if (r_cnt == c_LAST_ITER) w_state_nxt = c_FIX;
            c_FIX:   w_state_nxt = c_DONE;
            c_DONE:  if (bus.out_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
        if (w_kill) w_state_nxt = c_IDLE;
    end

    // Operand capture, divider iteration and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 3'd0;
            r_vj     <= 32'd0;
            r_vk     <= 32'd0;
            r_tag    <= '0;
            r_result <= 32'd0;
            r_cnt    <= 6'd0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_dvs    <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            r_op    <= w_f3;
            r_vj    <= bus.in_vj;
            r_vk    <= bus.in_vk;
            r_tag   <= bus.in_tag;
            r_cnt   <= 6'd0;
            r_quo   <= w_abs_a;
            r_rem   <= 32'd0;
            r_dvs   <= w_abs_b;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            if (w_special) r_result <= w_special_val;
        end else begin
            case (r_state)
                c_MUL: r_result <= w_mul_res;
                c_DIV: begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + 6'd1;
                end
                c_FIX: r_result <= w_div_res;
                default: ;
            endcase
        end
    end

    // Speculative mask tracking: resolved-correct branches drop out of the mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_spec <= 6'd0;
        else if (w_accept)        r_spec <= bus.in_spec_tag;
        else if (bus.flush_valid) r_spec <= r_spec & ~bus.flush_mask;
    end

    assign bus.in_ready     = (r_state == c_IDLE);
    assign bus.out_valid    = (r_state == c_DONE);
    assign bus.out_value    = r_result;
    assign bus.out_tag      = r_tag;
    assign bus.out_spec_tag = r_spec;

endmodule
`default_nettype wire

// File: tb/tb_exec_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_muldiv
// Brief    : Self-checking bench for exec_muldiv with an arithmetic reference
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_muldiv;
    localparam int BUF_SIZE_LOG = 4;

    logic clk = 1'b0;
    logic rst_n;

    exec_muldiv_if #(.BUF_SIZE_LOG(BUF_SIZE_LOG)) bus ();

    exec_muldiv #(.BUF_SIZE_LOG(BUF_SIZE_LOG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: an op is either absent or counting down to visibility
    logic                  m_busy;
    int                    m_left;
    logic [31:0]           m_val;
    logic [BUF_SIZE_LOG:0] m_tag;
    logic [5:0]            m_spec;

    logic [2:0]  d_op  [12] = '{3'd1, 3'd3, 3'd0, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'h0000_1234, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [12] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          d_lat [12] = '{2, 2, 2, 2, 34, 34, 34, 34, 1, 1, 1, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (op)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            default:    p = '0;
        endcase
        if (op == 3'd0) return p[31:0];
        if (!op[2])     return p[63:32];
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0])      return op[1] ? (a % b) : (a / b);
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 2;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        case ($urandom % 6)
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom % 20);
            default: v = 32'($urandom);
        endcase
        return v;
    endfunction

    // Reference model advances on the same edge the unit samples its inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_val  <= '0;
            m_tag  <= '0;
            m_spec <= '0;
        end else if (m_busy) begin
            if (bus.flush_valid && (bus.flush_mask & m_spec) != 6'd0) m_busy <= 1'b0;
            else if (m_left == 0) begin
                if (bus.out_ready) m_busy <= 1'b0;
            end else m_left <= m_left - 1;
        end else if (bus.in_valid && !(bus.flush_valid && (bus.flush_mask & bus.in_spec_tag) != 6'd0)) begin
            m_busy <= 1'b1;
            m_left <= ref_lat(bus.in_op[2:0], bus.in_vj, bus.in_vk) - 1;
            m_val  <= ref_res(bus.in_op[2:0], bus.in_vj, bus.in_vk);
            m_tag  <= bus.in_tag;
            m_spec <= bus.in_spec_tag;
        end
    end

    // Cycle-by-cycle comparison against the reference
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(bus.in_ready), 32'(!m_busy));
            chk("out_valid", 32'(bus.out_valid), 32'(m_busy && m_left == 0));
            if (m_busy && m_left == 0) begin
                chk("out_value", bus.out_value, m_val);
                chk("out_tag", 32'(bus.out_tag), 32'(m_tag));
                chk("out_spec_tag", 32'(bus.out_spec_tag), 32'(m_spec));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [BUF_SIZE_LOG:0] tag, input logic [5:0] spec);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("issue_wait", 32'(n < 100), 32'd1);
        bus.in_op       = {7'($urandom), op};
        bus.in_vj       = a;
        bus.in_vk       = b;
        bus.in_tag      = tag;
        bus.in_spec_tag = spec;
        bus.in_valid    = 1'b1;
        @(negedge clk);
        bus.in_valid    = 1'b0;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!bus.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) chk("wait_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        int lat;
        int seen;
        bus.in_valid    = 1'b0;
        bus.in_op       = '0;
        bus.in_vj       = '0;
        bus.in_vk       = '0;
        bus.in_tag      = '0;
        bus.in_spec_tag = '0;
        bus.flush_valid = 1'b0;
        bus.flush_mask  = '0;
        bus.out_ready   = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_value", bus.out_value, 32'd0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_out_spec", 32'(bus.out_spec_tag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Hand-computed results and latencies
        for (int i = 0; i < 12; i++) begin
            issue(d_op[i], d_a[i], d_b[i], 5'(i * 3 + 16 * (i % 2)), 6'd0);
            wait_done(1, lat);
            chk($sformatf("dir%0d_value", i), bus.out_value, d_exp[i]);
            chk($sformatf("dir%0d_latency", i), 32'(lat), 32'(d_lat[i]));
            @(negedge clk);
        end

        // Result bus backpressure
        bus.out_ready = 1'b0;
        issue(3'd0, 32'd7, 32'd6, 5'h15, 6'b100001);
        wait_done(1, lat);
        chk("bp_latency", 32'(lat), 32'd2);
        chk("bp_value", bus.out_value, 32'd42);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_value", bus.out_value, 32'd42);
            chk("bp_hold_tag", 32'(bus.out_tag), 32'h15);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        issue(3'd3, 32'h8000_0000, 32'd4, 5'h03, 6'd0);
        wait_done(1, lat);
        chk("bp_next_latency", 32'(lat), 32'd2);
        chk("bp_next_value", bus.out_value, 32'd2);
        @(negedge clk);

        // Matching flush during divide iterations
        issue(3'd4, 32'd1000, 32'd3, 5'h11, 6'b000100);
        repeat (9) @(negedge clk);
        bus.flush_valid = 1'b1;
        bus.flush_mask  = 6'b000100;
        @(negedge clk);
        bus.flush_valid = 1'b0;
        bus.flush_mask  = 6'd0;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        chk("flush_no_result", 32'(seen), 32'd0);

        // Non-matching flush leaves the divide intact
        issue(3'd4, 32'd1000, 32'd3, 5'h12, 6'b000100);
        repeat (9) @(negedge clk);
        bus.flush_valid = 1'b1;
        bus.flush_mask  = 6'b000010;
        @(negedge clk);
        bus.flush_valid = 1'b0;
        bus.flush_mask  = 6'd0;
        wait_done(11, lat);
        chk("noflush_latency", 32'(lat), 32'd34);
        chk("noflush_value", bus.out_value, 32'd333);
        chk("noflush_spec", 32'(bus.out_spec_tag), 32'b000100);
        @(negedge clk);

        // Flush in the accept cycle suppresses the accept
        bus.in_op       = 10'd4;
        bus.in_vj       = 32'd9;
        bus.in_vk       = 32'd0;
        bus.in_tag      = 5'h07;
        bus.in_spec_tag = 6'b000001;
        bus.in_valid    = 1'b1;
        bus.flush_valid = 1'b1;
        bus.flush_mask  = 6'b000011;
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.flush_valid = 1'b0;
        bus.flush_mask  = 6'd0;
        chk("flush_accept_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_accept_no_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);

        // Reset in the middle of a divide
        issue(3'd5, 32'hDEAD_BEEF, 32'd17, 5'h1A, 6'b010000);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_out_value", bus.out_value, 32'd0);
        chk("rst_mid_out_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_mid_out_spec", 32'(bus.out_spec_tag), 32'd0);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd5, 5'h1F, 6'd0);
        wait_done(1, lat);
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_value", bus.out_value, 32'd15);
        chk("post_rst_tag", 32'(bus.out_tag), 32'h1F);
        @(negedge clk);

        // Randomized traffic with backpressure and flushes
        for (int cyc = 0; cyc < 8000; cyc++) begin
            bus.out_ready   = ($urandom % 4) != 0;
            bus.flush_valid = ($urandom % 24) == 0;
            bus.flush_mask  = 6'(1 << ($urandom % 6));
            if (bus.in_ready && ($urandom % 3) == 0) begin
                bus.in_op       = 10'($urandom);
                bus.in_vj       = rnd_val();
                bus.in_vk       = rnd_val();
                bus.in_tag      = 5'($urandom);
                bus.in_spec_tag = (($urandom % 3) == 0) ? 6'd0 : 6'($urandom);
                bus.in_valid    = 1'b1;
            end else begin
                bus.in_valid    = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid    = 1'b0;
        bus.flush_valid = 1'b0;
        bus.flush_mask  = 6'd0;
        bus.out_ready   = 1'b1;
        repeat (60) @(negedge clk);
        chk("drain_idle", 32'(bus.in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
